// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- stage-1 fetch sequencer.
//
// Drives the PC register controls (pc_sel / pc_stall) and owns the single
// outstanding I-cache request/response handshake.
// It handles three cases:
//   - a post-reset hold-off before the first fetch;
//   - back-end hazard stalls;
//   - branch/jump redirects from execute, including squashing a wrong-path
//     response that is already in flight.
//
// Optional build macro: FETCH_CTRL_PERF_EN adds saturating performance counters.
//
// Ports:
//   clk                clock, all state on posedge
//   reset              asynchronous, active-low reset
//   pc_in              current PC register value
//   icache_addr        request address (pc_in)
//   icache_req_valid   request valid
//   icache_req_ready   I-cache accepts request this cycle
//   icache_resp_valid  instruction data valid, held until consumed
//   icache_resp_ready  controller consumes response this cycle
//   backend_stall      downstream hazard stall
//   redirect_valid     taken branch/jump pulse, target is ALU_Out at the PC mux
//   pc_sel             1 = PC loads ALU_Out at next edge
//   pc_stall           1 = PC holds
//   inst_valid         consumed response is a real instruction
//   kill               flush younger stage-1/2 instruction
//   perf_fetch_cnt     (FETCH_CTRL_PERF_EN) inst_valid cycles
//   perf_stall_cnt     (FETCH_CTRL_PERF_EN) non-BOOT cycles with pc_stall=1
//   perf_redirect_cnt  (FETCH_CTRL_PERF_EN) accepted redirects
module fetch_ctrl #(
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] icache_addr,
    output logic              icache_req_valid,
    input  logic              icache_req_ready,
    input  logic              icache_resp_valid,
    output logic              icache_resp_ready,
    input  logic              backend_stall,
    input  logic              redirect_valid,
    output logic              pc_sel,
    output logic              pc_stall,
    output logic              inst_valid,
    output logic              kill
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt,
    output logic [15:0]       perf_redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD);

    state_t     state;
    logic [3:0] hold_cnt;
    logic       redir;
    logic       req_fire;
    logic       resp_fire;

    // Outputs are combinational from state and inputs.
    always_comb begin
        icache_addr       = pc_in;
        icache_req_valid  = 1'b0;
        icache_resp_ready = 1'b0;
        pc_sel            = 1'b0;
        pc_stall          = 1'b1;
        inst_valid        = 1'b0;
        kill              = 1'b0;
        redir             = redirect_valid && (state != BOOT);

        case (state)
            REQ: begin
                icache_req_valid = 1'b1;
            end
            WAIT: begin
                // A redirect forces consumption so a wrong-path response is
                // drained immediately rather than left for DRAIN.
                icache_resp_ready = !backend_stall || redirect_valid;
                if (icache_resp_valid && icache_resp_ready && !redirect_valid) begin
                    inst_valid = 1'b1;
                    pc_stall   = 1'b0;
                end
            end
            DRAIN: begin
                icache_resp_ready = 1'b1;
            end
            default: ;
        endcase

        // Redirect wins over everything else outside BOOT.
        if (redir) begin
            pc_sel   = 1'b1;
            pc_stall = 1'b0;
            kill     = 1'b1;
        end

        req_fire  = icache_req_valid && icache_req_ready;
        resp_fire = icache_resp_valid && icache_resp_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            hold_cnt <= HOLD_INIT;
        end else begin
            case (state)
                BOOT: begin
                    hold_cnt <= hold_cnt - 4'd1;
                    if (hold_cnt == 4'd1)
                        state <= REQ;
                end
                REQ: begin
                    // Accepted alongside a redirect: the request is wrong-path
                    // and its response must be discarded.
                    if (req_fire)
                        state <= redir ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (resp_fire)
                        state <= REQ;
                    else if (redir)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // A redirect here only re-steers the PC; the pending
                    // response is still the one being drained.
                    if (resp_fire)
                        state <= REQ;
                end
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt    <= '0;
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (inst_valid && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state != BOOT) && pc_stall && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redir && (perf_redirect_cnt != '1))
                perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic, scored against a transaction-level model (outstanding/discard
// bookkeeping and an expected PC) through an expectation queue.
module tb_fetch_ctrl;

    localparam int unsigned RESET_HOLD = 2;
    localparam int unsigned ADDR_W     = 32;
    localparam logic [31:0] PC_RESET   = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] icache_addr;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic        icache_resp_ready;
    logic        backend_stall;
    logic        redirect_valid;
    logic        pc_sel;
    logic        pc_stall;
    logic        inst_valid;
    logic        kill;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_redirect_cnt;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_HOLD(RESET_HOLD),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_in            (pc_in),
        .icache_addr      (icache_addr),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_resp_valid(icache_resp_valid),
        .icache_resp_ready(icache_resp_ready),
        .backend_stall    (backend_stall),
        .redirect_valid   (redirect_valid),
        .pc_sel           (pc_sel),
        .pc_stall         (pc_stall),
        .inst_valid       (inst_valid),
        .kill             (kill)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt),
        .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    typedef struct {
        logic        req_valid;
        logic [31:0] addr;
        logic        resp_ready;
        logic        sel;
        logic        stall;
        logic        iv;
        logic        kill;
        int          fetch_cnt;
        int          stall_cnt;
        int          redir_cnt;
    } exp_s;

    exp_s exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: fetch is idle (wants to request), has one response
    // outstanding, or has one outstanding that is known to be wrong-path.
    int          boot_left;
    bit          outst;
    bit          disc;
    int          resp_wait;
    logic [31:0] m_pc;
    int          m_fetch, m_stall, m_redir;

    // Environment: PC register driven by the DUT's own controls.
    logic [31:0] env_pc;
    logic [31:0] cur_alu;
    logic        last_sel;
    logic        last_stall;

    task automatic model_reset();
        boot_left = RESET_HOLD;
        outst     = 1'b0;
        disc      = 1'b0;
        resp_wait = 0;
        m_pc      = PC_RESET;
        m_fetch   = 0;
        m_stall   = 0;
        m_redir   = 0;
        env_pc    = PC_RESET;
    endtask

    task automatic idle_inputs();
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b0;
        backend_stall     = 1'b0;
        redirect_valid    = 1'b0;
        pc_in             = env_pc;
        cur_alu           = '0;
    endtask

    // One clock slot, entered at posedge+1; returns at the next posedge+1.
    task automatic cycle(input bit rr, input bit bs, input bit rd,
                         input logic [31:0] alu, input int lat);
        exp_s e;
        bit   boot, redir, rv, consumed, accepted;
        rv    = outst && (resp_wait == 0);
        boot  = boot_left > 0;
        redir = rd && !boot;

        pc_in             = env_pc;
        icache_req_ready  = rr;
        icache_resp_valid = rv;
        backend_stall     = bs;
        redirect_valid    = rd;
        cur_alu           = alu;

        e.req_valid  = !boot && !outst;
        e.addr       = m_pc;
        e.resp_ready = outst && (disc || !bs || rd);
        e.iv         = outst && !disc && rv && e.resp_ready && !rd;
        e.sel        = redir;
        e.kill       = redir;
        e.stall      = !(redir || e.iv);
        e.fetch_cnt  = m_fetch;
        e.stall_cnt  = m_stall;
        e.redir_cnt  = m_redir;
        exp_q.push_back(e);

        consumed = rv && e.resp_ready;
        accepted = e.req_valid && rr;
        if (redir)
            m_pc = alu;
        else if (!e.stall)
            m_pc = m_pc + 32'd4;
        if (consumed) begin
            outst = 1'b0;
        end else if (accepted) begin
            outst     = 1'b1;
            disc      = redir;
            resp_wait = lat;
        end else if (outst) begin
            if (redir)
                disc = 1'b1;
            if (resp_wait > 0)
                resp_wait--;
        end
        if (e.iv)
            m_fetch++;
        if (!boot && e.stall)
            m_stall++;
        if (redir)
            m_redir++;
        if (boot_left > 0)
            boot_left--;

        @(posedge clk);
        #1;
        if (last_sel)
            env_pc = cur_alu;
        else if (!last_stall)
            env_pc = env_pc + 32'd4;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        idle_inputs();
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        idle_inputs();
    endtask

    // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
    task automatic mid_reset();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (icache_req_valid !== 1'b0 || icache_resp_ready !== 1'b0 ||
            pc_sel !== 1'b0 || pc_stall !== 1'b1 || inst_valid !== 1'b0 ||
            kill !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got rv=%b rr=%b sel=%b stall=%b iv=%b kill=%b, want 0 0 0 1 0 0",
                     icache_req_valid, icache_resp_ready, pc_sel, pc_stall, inst_valid, kill);
        end
`ifdef FETCH_CTRL_PERF_EN
        vectors++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0 || perf_redirect_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL perf_reset: got %0d %0d %0d, want 0 0 0",
                     perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt);
        end
`endif
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        idle_inputs();
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_s e;
        bit   bad;
        last_sel   = 1'b0;
        last_stall = 1'b1;
        forever begin
            @(negedge clk);
            last_sel   = pc_sel;
            last_stall = pc_stall;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                bad = (icache_req_valid !== e.req_valid) ||
                      (e.req_valid && (icache_addr !== e.addr)) ||
                      (icache_resp_ready !== e.resp_ready) ||
                      (pc_sel !== e.sel) || (pc_stall !== e.stall) ||
                      (inst_valid !== e.iv) || (kill !== e.kill);
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL cycle @%0t: got rv=%b addr=%h rr=%b sel=%b stall=%b iv=%b kill=%b, want rv=%b addr=%h rr=%b sel=%b stall=%b iv=%b kill=%b",
                             $time, icache_req_valid, icache_addr, icache_resp_ready, pc_sel,
                             pc_stall, inst_valid, kill, e.req_valid, e.addr, e.resp_ready,
                             e.sel, e.stall, e.iv, e.kill);
                end
`ifdef FETCH_CTRL_PERF_EN
                vectors++;
                if (perf_fetch_cnt !== 32'(e.fetch_cnt) || perf_stall_cnt !== 32'(e.stall_cnt) ||
                    perf_redirect_cnt !== 16'(e.redir_cnt)) begin
                    miscompares++;
                    $display("FAIL perf @%0t: got fetch=%0d stall=%0d redir=%0d, want %0d %0d %0d",
                             $time, perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt,
                             e.fetch_cnt, e.stall_cnt, e.redir_cnt);
                end
`endif
            end
        end
    end

    initial begin
        logic [31:0] a;
        model_reset();
        idle_inputs();
        apply_reset(3);

        // Boot hold-off, then a fetch with one-cycle response latency.
        repeat (4) cycle(1, 0, 0, '0, 0);
        // Response held under a 4-cycle back-end stall.
        cycle(1, 0, 0, '0, 0);
        repeat (4) cycle(1, 1, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);
        // Redirect in WAIT before the response arrives.
        cycle(1, 0, 0, '0, 2);
        cycle(1, 0, 1, 32'h0000_3000, 0);
        repeat (4) cycle(1, 0, 0, '0, 0);
        // Redirect coincident with a response under back-end stall.
        cycle(1, 0, 0, '0, 0);
        cycle(1, 1, 1, 32'h0000_4000, 0);
        repeat (4) cycle(1, 0, 0, '0, 0);
        // Reset while waiting for a response.
        cycle(1, 0, 0, '0, 3);
        cycle(0, 0, 0, '0, 0);
        mid_reset();
        // Boot again: five fetches and one redirect.
        repeat (2) cycle(1, 0, 0, '0, 0);
        repeat (5) begin
            cycle(1, 0, 0, '0, 0);
            cycle(1, 0, 0, '0, 0);
        end
        cycle(1, 0, 1, 32'h0000_5000, 0);
        cycle(1, 0, 0, '0, 0);

        // Random traffic with an intermediate reset.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000)
                apply_reset(2);
            a      = $urandom;
            a[1:0] = 2'b00;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, a, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
